// File: rtl/op_mode_controller.sv
// Debounces the switch-encoder op code and converts it into an exclusive,
// handshaked unit enable with a one-cycle start pulse and an invalid-op blink LED.
module op_mode_controller #(
  parameter int STABLE_CYCLES = 16,
  parameter int BLINK_PERIOD  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] op_in,
  input  logic       busy,
  output logic [2:0] active_op,
  output logic [4:0] mode_en,
  output logic       mode_start,
  output logic       led_err
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(STABLE_CYCLES - 2);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t        state_r;
  logic [2:0]    cand_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    filt_op_r;
  logic [BW-1:0] blink_r;

  function automatic logic [4:0] onehot(input logic [2:0] op);
    case (op)
      3'd1:    onehot = 5'b10000;
      3'd2:    onehot = 5'b01000;
      3'd3:    onehot = 5'b00100;
      3'd4:    onehot = 5'b00010;
      3'd5:    onehot = 5'b00001;
      default: onehot = 5'b00000;
    endcase
  endfunction

  function automatic logic [2:0] map_op(input logic [2:0] op);
    case (op)
      3'd6, 3'd7: map_op = 3'd0;
      default:    map_op = op;
    endcase
  endfunction

  // Debounce filter: filt_op loads on the edge where cand has been seen STABLE_CYCLES times
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_r    <= 3'd0;
      cnt_r     <= '0;
      filt_op_r <= 3'd0;
    end else if (op_in != cand_r) begin
      cand_r <= op_in;
      cnt_r  <= '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CW'(1);
      if (cnt_r == CNT_LOAD) begin
        filt_op_r <= map_op(cand_r);
      end else begin
        filt_op_r <= filt_op_r;
      end
    end else begin
      filt_op_r <= map_op(cand_r);
    end
  end

  // Mode ownership FSM with registered enable, owner and start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      active_op  <= 3'd0;
      mode_en    <= 5'b00000;
      mode_start <= 1'b0;
    end else begin
      mode_start <= 1'b0;
      case (state_r)
        IDLE: begin
          if (filt_op_r != 3'd0) begin
            active_op  <= filt_op_r;
            mode_en    <= onehot(filt_op_r);
            mode_start <= 1'b1;
            state_r    <= ACTIVE;
          end else begin
            state_r <= IDLE;
          end
        end
        ACTIVE: begin
          if (filt_op_r == active_op) begin
            state_r <= ACTIVE;
          end else if (busy) begin
            mode_en <= 5'b00000;
            state_r <= DRAIN;
          end else if (filt_op_r != 3'd0) begin
            active_op  <= filt_op_r;
            mode_en    <= onehot(filt_op_r);
            mode_start <= 1'b1;
            state_r    <= ACTIVE;
          end else begin
            active_op <= 3'd0;
            mode_en   <= 5'b00000;
            state_r   <= IDLE;
          end
        end
        DRAIN: begin
          // The old owner may be re-granted here; it still gets a fresh start pulse
          if (busy) begin
            state_r <= DRAIN;
          end else if (filt_op_r != 3'd0) begin
            active_op  <= filt_op_r;
            mode_en    <= onehot(filt_op_r);
            mode_start <= 1'b1;
            state_r    <= ACTIVE;
          end else begin
            active_op <= 3'd0;
            state_r   <= IDLE;
          end
        end
        default: begin
          active_op <= 3'd0;
          mode_en   <= 5'b00000;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Invalid-op indicator: toggles every BLINK_PERIOD cycles while filt_op is 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_r <= '0;
      led_err <= 1'b0;
    end else if (filt_op_r == 3'd0) begin
      if (blink_r == BLINK_MAX) begin
        blink_r <= '0;
        led_err <= ~led_err;
      end else begin
        blink_r <= blink_r + BW'(1);
      end
    end else begin
      blink_r <= '0;
      led_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_op_mode_controller.sv
// Randomized + directed bench for op_mode_controller with a cycle-level
// behavioural model feeding a scoreboard that a separate monitor drains.
module tb_op_mode_controller;

  localparam int S  = 4;
  localparam int BP = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] op_in = 3'd0;
  logic       busy  = 1'b0;
  logic [2:0] active_op;
  logic [4:0] mode_en;
  logic       mode_start;
  logic       led_err;

  op_mode_controller #(.STABLE_CYCLES(S), .BLINK_PERIOD(BP)) dut (
    .clk(clk), .rst_n(rst_n), .op_in(op_in), .busy(busy),
    .active_op(active_op), .mode_en(mode_en), .mode_start(mode_start), .led_err(led_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] en;
    logic       st;
    logic       led;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: sample history, filtered op, owner, enable, LED
  int   hist[$];
  int   m_filt  = 0;
  int   m_owner = 0;
  int   m_zrun  = 0;
  bit   m_en    = 1'b0;
  bit   m_led   = 1'b0;
  bit   m_start = 1'b0;
  bit   m_same  = 1'b0;
  exp_t m_e;
  exp_t mon_e;
  logic [4:0] top_bit = 5'b10000;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: one step per clock edge, rules applied to pre-edge filtered op
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      exp_q.delete();
      grant_q.delete();
      m_filt = 0; m_owner = 0; m_zrun = 0; m_en = 1'b0; m_led = 1'b0;
    end else begin
      m_start = 1'b0;
      if (m_owner == 0) begin
        if (m_filt != 0) begin m_owner = m_filt; m_en = 1'b1; m_start = 1'b1; end
      end else if (m_en) begin
        if (m_filt != m_owner) begin
          if (busy) m_en = 1'b0;
          else if (m_filt != 0) begin m_owner = m_filt; m_start = 1'b1; end
          else begin m_owner = 0; m_en = 1'b0; end
        end
      end else if (!busy) begin
        if (m_filt != 0) begin m_owner = m_filt; m_en = 1'b1; m_start = 1'b1; end
        else m_owner = 0;
      end
      if (m_filt == 0) begin
        m_zrun++;
        if (m_zrun % BP == 0) m_led = !m_led;
      end else begin
        m_zrun = 0;
        m_led  = 1'b0;
      end
      hist.push_back(int'(op_in));
      if (hist.size() > S) void'(hist.pop_front());
      if (hist.size() == S) begin
        m_same = 1'b1;
        foreach (hist[i]) if (hist[i] != hist[0]) m_same = 1'b0;
        if (m_same) m_filt = (hist[0] > 5) ? 0 : hist[0];
      end
      m_e.op  = 3'(m_owner);
      m_e.en  = m_en ? (top_bit >> (m_owner - 1)) : 5'b00000;
      m_e.st  = m_start;
      m_e.led = m_led;
      exp_q.push_back(m_e);
      if (m_start) grant_q.push_back(m_owner);
    end
  end

  // Monitor: compares DUT outputs against queued expectations away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_active_op", int'(active_op), 0);
      check("rst_mode_en", int'(mode_en), 0);
      check("rst_mode_start", int'(mode_start), 0);
      check("rst_led_err", int'(led_err), 0);
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("active_op", int'(active_op), int'(mon_e.op));
      check("mode_en", int'(mode_en), int'(mon_e.en));
      check("mode_start", int'(mode_start), int'(mon_e.st));
      check("led_err", int'(led_err), int'(mon_e.led));
      if (mode_start) begin
        if (grant_q.size() == 0) check("grant_unexpected", int'(active_op), 0);
        else check("grant_op", int'(active_op), grant_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic b, input int n);
    op_in = op;
    busy  = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_active_op", int'(active_op), 0);
    check("async_rst_mode_en", int'(mode_en), 0);
    check("async_rst_mode_start", int'(mode_start), 0);
    check("async_rst_led_err", int'(led_err), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    // clean selection, direct switch, glitch rejection
    drive(3'd4, 1'b0, 8);
    drive(3'd1, 1'b0, 8);
    drive(3'd3, 1'b0, 3);
    drive(3'd1, 1'b0, 6);
    // drain handshake with long busy
    drive(3'd2, 1'b0, 8);
    drive(3'd5, 1'b1, 16);
    drive(3'd5, 1'b0, 4);
    // invalid while active, 0 and 7
    drive(3'd3, 1'b0, 8);
    drive(3'd0, 1'b0, 12);
    drive(3'd3, 1'b0, 8);
    drive(3'd7, 1'b0, 12);
    // re-grant of the old owner after draining
    drive(3'd1, 1'b0, 8);
    drive(3'd4, 1'b1, 6);
    drive(3'd1, 1'b1, 6);
    drive(3'd1, 1'b0, 4);
    // async reset while draining, then filter restarts
    drive(3'd2, 1'b0, 8);
    drive(3'd5, 1'b1, 6);
    async_reset();
    drive(3'd5, 1'b1, 8);
    drive(3'd5, 1'b0, 4);
    // randomized traffic with short glitches and sticky busy
    for (int i = 0; i < 300; i++) begin
      drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0), $urandom_range(1, 10));
    end
    drive(3'd0, 1'b0, 4);
    check("grants_outstanding", grant_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
